// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux onto one valid/ready channel.
// A grant lasts at most BURST accepted beats, or ends early when the owner drops req.
module rr_mux4_arbiter #(
    parameter int WIDTH = 1,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       req_mask,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic [3:0]       ack,
    output logic             busy
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [CW-1:0] beat_cnt;

    logic [3:0] elig;
    logic       xfer;
    logic       rel;
    logic [1:0] start;
    logic [2:0] pick_r;

    // Returns {found, index}; the scan runs backwards so the lowest offset from start wins.
    function automatic logic [2:0] pick(input logic [1:0] from, input logic [3:0] e);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k);
            if (e[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    // Handshake: a beat moves when out_valid and out_ready are both high in the same cycle;
    // the owner holds req and data until its ack, and out_valid never drops without a transfer.
    always_comb begin
        elig      = req & req_mask;
        busy      = (state == GRANT);
        out_valid = busy & req[sel] & ~rst;
        case (sel)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
        xfer   = out_valid & out_ready;
        ack    = xfer ? gnt : 4'b0000;
        rel    = busy & ((xfer & (beat_cnt == LAST_BEAT)) | ~req[sel]);
        // On release the search starts just past the outgoing owner, so it wins again only when alone.
        start  = rel ? (sel + 2'd1) : ptr;
        pick_r = pick(start, elig);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= 2'd0;
            gnt      <= 4'b0000;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_r[2]) begin
                        state    <= GRANT;
                        sel      <= pick_r[1:0];
                        gnt      <= 4'b0001 << pick_r[1:0];
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr      <= sel + 2'd1;
                        beat_cnt <= '0;
                        if (pick_r[2]) begin
                            sel <= pick_r[1:0];
                            gnt <= 4'b0001 << pick_r[1:0];
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 datapath mux. Four requesters each present a data word with a request. The block grants one requester at a time and drives the mux select, steering that requester's data onto a single valid/ready output channel. Grant tenure is limited to BURST beats, so one requester cannot starve the others.

Parameters:
WIDTH, 1, data width of each input word and of out_data
BURST, 4, maximum beats (accepted transfers) per grant; legal range 1..16

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
req  input  4  request per requester; bit i belongs to in_i
req_mask  input  4  per-requester enable; 0 excludes that requester from new grants
in0  input  WIDTH  requester 0 data
in1  input  WIDTH  requester 1 data
in2  input  WIDTH  requester 2 data
in3  input  WIDTH  requester 3 data
out_ready  input  1  downstream ready
out_data  output  WIDTH  selected data, equal to in[sel]
out_valid  output  1  output beat valid
sel  output  2  registered mux select, index of the granted requester
gnt  output  4  registered one-hot grant; all zero when idle
ack  output  4  one-hot beat-accepted pulse to the granted requester
busy  output  1  high while a grant is held

Behaviour:
- Reset is synchronous and active-high. At the clk edge with rst=1: state=IDLE, ptr=0, sel=0, gnt=0, beat_cnt=0.
- While rst=1, out_valid and ack are forced to 0 combinationally, including in the reset cycle itself. busy=0 after the reset edge.
- States: IDLE and GRANT. busy = (state==GRANT).
- Eligible requesters: elig = req & req_mask.
- Pick function: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first index with elig set.
- IDLE:
  - If elig is nonzero, go to GRANT at the next edge with sel=pick, gnt=onehot(pick), beat_cnt=0.
  - Latency from req to out_valid is 1 cycle.
  - If elig is zero, stay in IDLE.
- GRANT outputs:
  - out_valid = req[sel] & ~rst.
  - out_data = in[sel], fully combinational through the 4:1 mux.
  - ack[i] = gnt[i] & out_valid & out_ready.
- A transfer occurs in a cycle where out_valid=1 and out_ready=1.
- Requester rules:
  - Hold req and data stable until ack.
  - Req may drop only in the cycle after ack.
  - out_valid must not drop without a transfer.
- Release conditions (evaluated in GRANT):
  - (a) A transfer occurs with beat_cnt==BURST-1.
  - (b) req[sel]==0, meaning the requester finished after its last ack. No transfer occurs in this cycle.
- Otherwise, on a transfer, beat_cnt increments. Without a transfer all state holds; backpressure can last indefinitely.
- On release:
  - ptr = sel+1 mod 4.
  - Re-arbitrate in the same cycle using the current elig, with the search starting from the new ptr.
  - If any requester is eligible, re-grant at the next edge with no idle bubble. The released requester may win again only if no other requester is eligible.
  - If none is eligible, go to IDLE.
- req_mask changes never pre-empt a current grant. They affect only subsequent picks.
- beat_cnt width is clog2(BURST), minimum 1 bit. With BURST=1, every transfer releases.
- sel holds its last value in IDLE. gnt is zero in IDLE.
- Synchronous reset during GRANT abandons the grant at that edge. A beat presented in the reset cycle is not acked.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111, mask=1111, out_ready=1 -> out_valid=0, ack=0, gnt=0 throughout. In the first cycle after rst falls, state is still IDLE. The next cycle shows gnt=0001, sel=0, out_data=in0.
- Fairness: BURST=1, req=1111, out_ready=1, in_i=i+5 -> gnt sequence 0001, 0010, 0100, 1000, 0001. ack is one-hot every cycle and out_data follows 5, 6, 7, 8, 5 with no bubbles.
- Backpressure: only req[2] set, out_ready=0 for 5 cycles -> out_valid=1, sel=2, ack=0 held for all 5 cycles. Raising out_ready gives ack=0100 for exactly one cycle per beat.
- Burst limit: BURST=4, req[0] and req[3] held high, out_ready=1 -> 4 beats on sel=0, then 4 on sel=3, then 4 on sel=0. Switch-over occurs with zero idle cycles.
- Early finish: BURST=4, req=0010; req[1] drops after the 2nd ack -> the next cycle has out_valid=0 and releases. The block returns to IDLE with busy=0 and ptr=2; a later request on req[0] gets a grant with sel=0.
- Mask: during a grant to requester 0, set req_mask=1110 -> the current burst completes all 4 beats. Requester 0 then receives no further grants while requesters 1 to 3 rotate.
